// File: rtl/normalize_significand.sv
// normalize_significand
// Post-addition normalizer for a floating-point adder. Takes the raw magnitude sum
// {carry, hidden, fraction} and the common exponent, and produces a normalized fraction
// (hidden bit stripped) with an adjusted exponent. A carry-out is handled in one step by a
// right shift. Cancellation is handled by one left shift per cycle until the hidden bit is
// set, or until the exponent would drop below 1, in which case the result is flushed to zero.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  upstream handshake; in_ready is high only while idle
//   sum_in               raw adder magnitude, SIG_W+2 bits {carry, hidden, fraction}
//   exp_in, sign_in      common biased exponent and result sign
//   out_valid/out_ready  downstream handshake; out_valid is high only while a result is held
//   sig_out, exp_out     normalized fraction (no hidden bit) and adjusted exponent
//   sign_out             registered sign
//   overflow, underflow  exponent saturated to all-ones / result flushed to zero
module normalize_significand #(
  parameter int unsigned SIG_W = 23,
  parameter int unsigned EXP_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SIG_W+1:0] sum_in,
  input  logic [EXP_W-1:0] exp_in,
  input  logic             sign_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SIG_W-1:0] sig_out,
  output logic [EXP_W-1:0] exp_out,
  output logic             sign_out,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [EXP_W-1:0] ExpMax = '1;
  localparam logic [EXP_W-1:0] ExpOne = EXP_W'(1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  // Working sum without the carry bit: once accepted, the carry is already folded in.
  logic [SIG_W:0]   sum_q, sum_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic             sign_q, sign_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [EXP_W-1:0] exp_inc;

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    exp_d   = exp_q;
    sign_d  = sign_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    exp_inc = exp_in + ExpOne;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          sign_d  = sign_in;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          state_d = StDone;
          if (exp_in == ExpMax) begin
            // Input already at infinity exponent: saturate.
            sum_d = '0;
            exp_d = ExpMax;
            ovf_d = 1'b1;
          end else if (sum_in[SIG_W+1]) begin
            exp_d = exp_inc;
            if (exp_inc == ExpMax) begin
              sum_d = '0;
              ovf_d = 1'b1;
            end else begin
              // Truncating right shift, LSB dropped.
              sum_d = sum_in[SIG_W+1:1];
            end
          end else if (sum_in == '0) begin
            sum_d = '0;
            exp_d = '0;
          end else begin
            sum_d = sum_in[SIG_W:0];
            exp_d = exp_in;
            if (!sum_in[SIG_W]) begin
              state_d = StShift;
            end
          end
        end
      end

      StShift: begin
        if (sum_q[SIG_W]) begin
          state_d = StDone;
        end else if (exp_q > ExpOne) begin
          sum_d = {sum_q[SIG_W-1:0], 1'b0};
          exp_d = exp_q - ExpOne;
        end else begin
          sum_d   = '0;
          exp_d   = '0;
          unf_d   = 1'b1;
          state_d = StDone;
        end
      end

      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sum_q   <= '0;
      exp_q   <= '0;
      sign_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      exp_q   <= exp_d;
      sign_q  <= sign_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign sig_out   = sum_q[SIG_W-1:0];
  assign exp_out   = exp_q;
  assign sign_out  = sign_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_normalize_significand.sv
// Randomized self-checking bench for normalize_significand (default SIG_W=23, EXP_W=8).
// The reference model works on integer values: it locates the leading one arithmetically
// and derives the result and the acceptance-to-out_valid latency from that.
module tb_normalize_significand;

  localparam int SigW = 23;
  localparam int ExpW = 8;
  localparam int Hid  = 1 << SigW;
  localparam int Cry  = 1 << (SigW + 1);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [SigW+1:0] sum_in = '0;
  logic [ExpW-1:0] exp_in = '0;
  logic            sign_in = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [SigW-1:0] sig_out;
  logic [ExpW-1:0] exp_out;
  logic            sign_out;
  logic            overflow;
  logic            underflow;

  int n_vec = 0;
  int n_err = 0;

  normalize_significand #(.SIG_W(SigW), .EXP_W(ExpW)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum_in    (sum_in),
    .exp_in    (exp_in),
    .sign_in   (sign_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sig_out   (sig_out),
    .exp_out   (exp_out),
    .sign_out  (sign_out),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: latency counts clock edges from the accepting edge (inclusive) to the edge
  // after which out_valid is high.
  task automatic model(input int s, input int e, output int sig, output int ex,
                       output int ovf, output int unf, output int lat);
    int n;
    int t;
    ovf = 0;
    unf = 0;
    lat = 1;
    sig = 0;
    ex  = 0;
    if (e == 255) begin
      ex  = 255;
      ovf = 1;
    end else if (s >= Cry) begin
      ex = e + 1;
      if (ex == 255) ovf = 1;
      else sig = (s / 2) % Hid;
    end else if (s != 0) begin
      n = 0;
      t = s;
      while (t < Hid) begin
        t = t * 2;
        n++;
      end
      if (n == 0) begin
        sig = s % Hid;
        ex  = e;
      end else if (n <= e - 1) begin
        sig = t % Hid;
        ex  = e - n;
        lat = n + 2;
      end else begin
        unf = 1;
        lat = ((e > 1) ? e - 1 : 0) + 2;
      end
    end
  endtask

  // Entered at #1 after a posedge with the DUT idle; leaves it idle at the same phase.
  task automatic run_txn(input int s, input int e, input logic sg, input int hold);
    int esig, eexp, eovf, eunf, elat, lat;
    logic [SigW-1:0] sig_h;
    logic [ExpW-1:0] exp_h;
    model(s, e, esig, eexp, eovf, eunf, elat);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    sum_in   = (SigW+2)'(s);
    exp_in   = ExpW'(e);
    sign_in  = sg;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    lat = 1;
    while (!out_valid && lat < 64) begin
      // Busy: extra requests with junk data must be ignored.
      in_valid = 1'($urandom);
      sum_in   = (SigW+2)'($urandom);
      exp_in   = ExpW'($urandom);
      @(posedge clk);
      #1;
      lat++;
    end
    in_valid = 1'b0;
    check("out_valid", 32'(out_valid), 32'd1);
    check("latency", 32'(lat), 32'(elat));
    check("sig_out", 32'(sig_out), 32'(esig));
    check("exp_out", 32'(exp_out), 32'(eexp));
    check("sign_out", 32'(sign_out), 32'(sg));
    check("overflow", 32'(overflow), 32'(eovf));
    check("underflow", 32'(underflow), 32'(eunf));
    check("in_ready_done", 32'(in_ready), 32'd0);
    sig_h = sig_out;
    exp_h = exp_out;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_ready", 32'(in_ready), 32'd0);
      check("hold_sig", 32'(sig_out), 32'(sig_h));
      check("hold_exp", 32'(exp_out), 32'(exp_h));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("release_valid", 32'(out_valid), 32'd0);
    check("release_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int s, e, k, p;
    #2;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sig", 32'(sig_out), 32'd0);
    check("rst_exp", 32'(exp_out), 32'd0);
    check("rst_flags", 32'({overflow, underflow, sign_out}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases.
    run_txn(32'h1800000, 127, 1'b0, 0);  // carry-out
    run_txn(32'h0C00000, 130, 1'b1, 0);  // already normalized
    run_txn(32'h0000001, 100, 1'b0, 0);  // full cancellation, longest shift
    run_txn(32'h0000100, 3, 1'b0, 0);    // underflow flush
    run_txn(32'h1000000, 254, 1'b1, 0);  // carry into all-ones exponent
    run_txn(32'h0400000, 255, 1'b0, 0);  // all-ones exponent on input
    run_txn(32'h0000000, 50, 1'b1, 0);   // exact zero
    run_txn(32'h0C00000, 130, 1'b0, 5);  // backpressure

    // Reset between clock edges while shifting.
    sum_in   = (SigW+2)'(1);
    exp_in   = ExpW'(100);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_data", 32'({sig_out, exp_out}), 32'd0);
    check("midrst_flags", 32'({overflow, underflow, sign_out}), 32'd0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("postrst_idle", 32'(out_valid), 32'd0);
    run_txn(32'h0000100, 30, 1'b1, 1);

    // Randomized cases.
    for (int i = 0; i < 200; i++) begin
      k = int'($urandom_range(0, 5));
      case (k)
        0: s = Cry | int'($urandom_range(0, Cry - 1));
        1: s = 0;
        2: s = Hid | int'($urandom_range(0, Hid - 1));
        default: begin
          p = int'($urandom_range(0, SigW - 1));
          s = (1 << p) | (int'($urandom) & ((1 << p) - 1));
        end
      endcase
      k = int'($urandom_range(0, 7));
      if (k == 0) e = 254;
      else if (k == 1) e = 255;
      else if (k <= 3) e = int'($urandom_range(0, 6));
      else e = int'($urandom_range(0, 255));
      run_txn(s, e, 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
